logic_gate_sequencer: RTL and testbench



---
 rtl/logic_gate_sequencer.sv | 153 +++++++++++++++
 tb/tb_logic_gate_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/logic_gate_sequencer.sv
// Self-test sequencer for a LogicGates block: steps A/B through 00..11, settles, checks outputs against a golden table.
// Optional build macro GATESEQ_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module logic_gate_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       gate_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_mask,
  output logic [7:0]       fail_gates
);

  localparam int unsigned GATE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef GATESEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ab_q, ab_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [3:0]          err_mask_q, err_mask_d;
  logic [GATE_W-1:0]   fail_gates_q, fail_gates_d;

  logic [GATE_W-1:0]   mism;
  logic                last_vec;

  // Expected {Xnor,Xor,Nor,Or,Nand,And,Not,Buf} for {a,b} = i
  function automatic logic [GATE_W-1:0] golden(input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    golden = 8'hAA;
      2'd1:    golden = 8'h5A;
      2'd2:    golden = 8'h59;
      default: golden = 8'h95;
    endcase
  endfunction

  assign mism     = gate_out ^ golden(idx_q);
  assign last_vec = (idx_q == IDX_W'(3)) || (STOP_ON_FAIL && (mism != '0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (cnt_q == CNT_LAST) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    idx_d        = idx_q;
    ab_d         = ab_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    fail_gates_d = fail_gates_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d        = '0;
          ab_d         = '0;
          cnt_d        = '0;
          err_mask_d   = '0;
          fail_gates_d = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      SETTLE: cnt_d = cnt_q + CNT_W'(1);
      CHECK: begin
        fail_gates_d          = fail_gates_q | mism;
        err_mask_d[idx_q]     = |mism;
        if (last_vec) begin
          // busy drops as done rises; pass reflects the final mask
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_mask_d == 4'b0000);
        end else begin
          idx_d = idx_q + IDX_W'(1);
          ab_d  = idx_q + IDX_W'(1);
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      ab_q         <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= '0;
      fail_gates_q <= '0;
    end else begin
      idx_q        <= idx_d;
      ab_q         <= ab_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      fail_gates_q <= fail_gates_d;
    end
  end

  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_mask   = err_mask_q;
  assign fail_gates = fail_gates_q;

endmodule

// File: tb/tb_logic_gate_sequencer.sv
// Bench for logic_gate_sequencer: a behavioural LogicGates model with stuck-at faults feeds the DUT.
// Honours GATESEQ_STOP_ON_FAIL_EN when the same macro is defined for the build.
module tb_logic_gate_sequencer;

  localparam int unsigned S  = 4;
  localparam int unsigned CW = 8;
`ifdef GATESEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] gate_out;
  logic       a, b, busy, done, pass;
  logic [3:0] err_mask;
  logic [7:0] fail_gates;
  logic [7:0] sa0, sa1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_gate_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_out(gate_out),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .fail_gates(fail_gates)
  );

  // Ideal gate behaviour, bit order {Xnor,Xor,Nor,Or,Nand,And,Not,Buf}
  function automatic logic [7:0] gates(input logic ai, input logic bi);
    return {~(ai ^ bi), ai ^ bi, ~(ai | bi), ai | bi, ~(ai & bi), ai & bi, ~ai, ai};
  endfunction

  assign gate_out = (gates(a, b) & ~sa0) | sa1;

  typedef struct {
    logic [7:0] f0;
    logic [7:0] f1;
    logic [3:0] em;
    logic [7:0] fg;
    logic       ps;
    int         nvec;
    int         extra;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: apply each vector to the faulty gate model and compare with ideal gates
  task automatic model(input logic [7:0] f0, input logic [7:0] f1,
                       output logic [3:0] em, output logic [7:0] fg,
                       output logic ps, output int nvec);
    logic [7:0] m;
    logic [1:0] vv;
    em = '0; fg = '0; nvec = 0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      m = ((gates(vv[1], vv[0]) & ~f0) | f1) ^ gates(vv[1], vv[0]);
      em[v] = |m;
      fg |= m;
      nvec = v + 1;
      if (STOP && (m != 0)) break;
    end
    ps = (em == 4'b0000);
  endtask

  // One full run with cycle-by-cycle a/b, busy and done checks; extra pulses start mid-run
  task automatic run_check(input vec_t t);
    int dc;
    int vi;
    dc = t.nvec * (S + 1) + 1;
    sa0 = t.f0;
    sa1 = t.f1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= dc + 1; c++) begin
      vi = (c - 1) / (S + 1);
      if (vi > t.nvec - 1) vi = t.nvec - 1;
      check("ab", {a, b}, 32'(vi));
      check("busy_done", {busy, done}, {30'd0, c < dc, c == dc});
      if (c == 1) check("cleared", {pass, err_mask, fail_gates}, 32'd0);
      start = (c == t.extra);
      @(negedge clk);
    end
    start = 1'b0;
    check("pass", pass, t.ps);
    check("err_mask", err_mask, t.em);
    check("fail_gates", fail_gates, t.fg);
  endtask

  vec_t tbl[4];
  vec_t rv;

  initial begin
    rst = 1'b1; start = 1'b0; sa0 = '0; sa1 = '0;
    // Known-answer cases: golden, And stuck-at-0, Not stuck-at-1, Buf stuck-at-1
    tbl[0] = '{8'h00, 8'h00, 4'b0000, 8'h00, 1'b1, 4, 7};
    tbl[1] = '{8'h04, 8'h00, 4'b1000, 8'h04, 1'b0, 4, 0};
`ifdef GATESEQ_STOP_ON_FAIL_EN
    tbl[2] = '{8'h00, 8'h02, 4'b0100, 8'h02, 1'b0, 3, 16};
    tbl[3] = '{8'h00, 8'h01, 4'b0001, 8'h01, 1'b0, 1, 3};
`else
    tbl[2] = '{8'h00, 8'h02, 4'b1100, 8'h02, 1'b0, 4, 21};
    tbl[3] = '{8'h00, 8'h01, 4'b0011, 8'h01, 1'b0, 4, 12};
`endif

    repeat (2) @(negedge clk);
    check("reset_state", {a, b, busy, done, pass, err_mask, fail_gates}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_check(tbl[i]);
    run_check(tbl[0]);

    // Reset during vector 2 settle discards the run
    sa0 = '0; sa1 = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2 * (S + 1) + 1) @(negedge clk);
    check("mid_ab", {a, b}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {a, b, busy, done, pass, err_mask, fail_gates}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("post_reset_idle", {busy, done}, 32'd0);
    end

    // Random stuck-at faults against the reference model
    for (int k = 0; k < 10; k++) begin
      rv.f0 = 8'($urandom) & 8'($urandom);
      rv.f1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
      model(rv.f0, rv.f1, rv.em, rv.fg, rv.ps, rv.nvec);
      rv.extra = int'($urandom_range(0, rv.nvec * (S + 1) + 1));
      run_check(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
